tone_note_detector: RTL and testbench

- Receive side of the tone generators: measures the period of an incoming square-wave tone and decodes it to a note index.
- The input is a single asynchronous square wave, either from a tone generator output or from an external pin.
- Used for loopback self-test of the music player and for a note display.
- Runs in the 100 MHz system clock domain.

---
 rtl/tone_pkg.sv | 31 +++
 rtl/tone_edge_sync.sv | 30 +++
 rtl/tone_note_detector.sv | 163 ++++++++++++++++
 tb/tb_tone_note_detector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone note detector: note table,
// note index width and the detector state encoding.
`timescale 1ns/1ps
package tone_pkg;

  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned NUM_NOTES = 8;

  // Entry [i] is the full period of note i in 100 MHz clocks; index 0 is unused
  // because note 0 means "none/unknown".
  typedef logic [NUM_NOTES:1][31:0] note_table_t;

  // Listed from C6 (index 8) down to C5 (index 1).
  localparam note_table_t NOTE_PERIOD = {
    32'd95557,   // C6
    32'd101238,  // B5
    32'd113636,  // A5
    32'd127553,  // G5
    32'd143172,  // F5
    32'd151686,  // E5
    32'd170262,  // D5
    32'd191113   // C5
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } det_state_t;

endpackage

// File: rtl/tone_edge_sync.sv
// Brings the asynchronous tone input into the clock domain and produces a
// single-cycle pulse on each rising edge of the synchronised signal.
`timescale 1ns/1ps
module tone_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tone_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two metastability stages followed by a delayed copy for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= tone_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/tone_note_detector.sv
// Measures the period of an incoming square-wave tone and decodes it to a
// note index, reporting a note only after several consecutive matching periods.
`timescale 1ns/1ps
module tone_note_detector
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W     = 18,
  parameter int unsigned TOL_SHIFT = 6,
  parameter int unsigned STABLE_N  = 3,
  parameter note_table_t NOTE_T    = NOTE_PERIOD
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              i_tone,
  output logic [NOTE_W-1:0] o_note,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_period,
  output logic              o_change
);

  localparam int unsigned       MATCH_W      = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;
  localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(STABLE_N);

  logic              rise;

  det_state_t        state_q,  state_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [NOTE_W-1:0] cand_q,   cand_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [NOTE_W-1:0] note_q,   note_d;
  logic              valid_q,  valid_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              change_q, change_d;

  logic [CNT_W:0]    measPeriod;
  logic [CNT_W-1:0]  periodSat;
  logic [NOTE_W-1:0] classNote;

  tone_edge_sync u_edge_sync (
    .clk_i  (clk_100MHz),
    .rst_i  (reset),
    .tone_i (i_tone),
    .rise_o (rise)
  );

  // Full period ends on the edge cycle, so it is one more than the count.
  // A period of 2^CNT_W only occurs when an edge lands on a saturated
  // counter; it does not fit the output, so it is reported as the maximum.
  assign measPeriod = {1'b0, count_q} + (CNT_W + 1)'(1);
  assign periodSat  = measPeriod[CNT_W] ? CNT_MAX : measPeriod[CNT_W-1:0];

  // Period counter: restarts on every edge, otherwise counts up and sticks at max.
  always_comb begin
    count_d = count_q;
    if (rise) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Classifier: lowest table index whose tolerance window contains the period.
  always_comb begin
    logic [CNT_W-1:0]        refT;
    logic [CNT_W-1:0]        tol;
    logic signed [CNT_W:0]   diff;
    logic [CNT_W:0]          mag;
    classNote = '0;
    for (int i = NUM_NOTES; i >= 1; i--) begin
      refT = NOTE_T[i][CNT_W-1:0];
      tol  = refT >> TOL_SHIFT;
      diff = $signed({1'b0, periodSat}) - $signed({1'b0, refT});
      mag  = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
      if (!measPeriod[CNT_W] && (mag <= {1'b0, tol})) begin
        classNote = NOTE_W'(i);
      end
    end
  end

  // Detector FSM next state and registered-output next values.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    match_d  = match_q;
    note_d   = note_q;
    valid_d  = valid_q;
    period_d = period_q;
    if (rise) begin
      case (state_q)
        IDLE: begin
          state_d = MEASURE;
        end
        MEASURE: begin
          period_d = periodSat;
          if ((classNote != '0) && (classNote == cand_q)) begin
            if (match_q != MATCH_TARGET) begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            cand_d  = classNote;
            match_d = (classNote != '0) ? MATCH_W'(1) : '0;
          end
          if (match_d == MATCH_TARGET) begin
            state_d = LOCKED;
            valid_d = 1'b1;
            note_d  = cand_d;
          end
        end
        LOCKED: begin
          period_d = periodSat;
          if (classNote != cand_q) begin
            state_d = MEASURE;
            valid_d = 1'b0;
            note_d  = '0;
            cand_d  = classNote;
            match_d = (classNote != '0) ? MATCH_W'(1) : '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (count_q == CNT_MAX) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      note_d   = '0;
      period_d = '0;
      cand_d   = '0;
      match_d  = '0;
    end
    change_d = valid_d && (!valid_q || (note_d != note_q));
  end

  // State, counter and output registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      cand_q   <= '0;
      match_q  <= '0;
      note_q   <= '0;
      valid_q  <= 1'b0;
      period_q <= '0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      period_q <= period_d;
      change_q <= change_d;
    end
  end

  assign o_note   = note_q;
  assign o_valid  = valid_q;
  assign o_period = period_q;
  assign o_change = change_q;

endmodule

// File: tb/tb_tone_note_detector.sv
// Bench for tone_note_detector using a note table scaled by 1/128 and a
// 12-bit counter so every scenario stays short.
`timescale 1ns/1ps
module tb_tone_note_detector;
  import tone_pkg::*;

  localparam int CW = 12;

  // Scaled periods: C6 B5 A5 G5 F5 E5 D5 C5 (indices 8..1).
  localparam note_table_t BENCH_TABLE = {
    32'd746, 32'd790, 32'd887, 32'd996, 32'd1118, 32'd1185, 32'd1330, 32'd1493
  };

  logic              clock = 1'b0;
  logic              reset;
  logic              tone;
  logic [NOTE_W-1:0] note;
  logic              valid;
  logic [CW-1:0]     period;
  logic              change;

  typedef struct {
    int note;
    int valid;
    int period;
    int change;
    int rise;
  } expect_t;

  expect_t expQ[$];
  expect_t monExp;

  int checks    = 0;
  int errors    = 0;
  int riseCount = 0;

  logic [NOTE_W-1:0] prevNote   = '0;
  logic              prevValid  = 1'b0;
  logic [CW-1:0]     prevPeriod = '0;
  logic              prevChange = 1'b0;

  always #5 clock = ~clock;

  tone_note_detector #(
    .CNT_W     (CW),
    .TOL_SHIFT (6),
    .STABLE_N  (3),
    .NOTE_T    (BENCH_TABLE)
  ) dut (
    .clk_100MHz (clock),
    .reset      (reset),
    .i_tone     (tone),
    .o_note     (note),
    .o_valid    (valid),
    .o_period   (period),
    .o_change   (change)
  );

  // Every visible change of the output tuple must match the next queued entry.
  always @(negedge clock) begin
    if ((note !== prevNote) || (valid !== prevValid) ||
        (period !== prevPeriod) || (change !== prevChange)) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_update: got note=%0d valid=%0d period=%0d change=%0d rise=%0d, none required",
                 note, valid, period, change, riseCount);
      end else begin
        monExp = expQ.pop_front();
        if ((note !== NOTE_W'(monExp.note)) || (valid !== 1'(monExp.valid)) ||
            (period !== CW'(monExp.period)) || (change !== 1'(monExp.change)) ||
            (riseCount != monExp.rise)) begin
          errors++;
          $display("[TB] FAIL update: got note=%0d valid=%0d period=%0d change=%0d rise=%0d, required note=%0d valid=%0d period=%0d change=%0d rise=%0d",
                   note, valid, period, change, riseCount,
                   monExp.note, monExp.valid, monExp.period, monExp.change, monExp.rise);
        end
      end
    end
    prevNote   = note;
    prevValid  = valid;
    prevPeriod = period;
    prevChange = change;
  end

  task automatic pushExp(input int n, input int v, input int p, input int c, input int r);
    expect_t e;
    e.note   = n;
    e.valid  = v;
    e.period = p;
    e.change = c;
    e.rise   = r;
    expQ.push_back(e);
  endtask

  // Drives n full periods of p clocks, each starting with a rising edge.
  task automatic applyStimulus(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      tone = 1'b1;
      riseCount++;
      repeat (p / 2) @(negedge clock);
      tone = 1'b0;
      repeat (p - p / 2) @(negedge clock);
    end
  endtask

  task automatic holdLow(input int n);
    tone = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  initial begin
    reset = 1'b1;
    tone  = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_note",   32'(note),   32'd0);
    checkOutput("reset_valid",  32'(valid),  32'd0);
    checkOutput("reset_period", 32'(period), 32'd0);
    checkOutput("reset_change", 32'(change), 32'd0);
    holdLow(10);

    $display("[TB] E5 lock");
    pushExp(0, 0, 1180, 0, 2);
    pushExp(3, 1, 1180, 1, 4);
    pushExp(3, 1, 1180, 0, 4);
    applyStimulus(1180, 5);

    $display("[TB] switch to A5 then C6");
    pushExp(0, 0, 887, 0, 7);
    pushExp(6, 1, 887, 1, 9);
    pushExp(6, 1, 887, 0, 9);
    applyStimulus(887, 4);
    pushExp(0, 0, 746, 0, 11);
    pushExp(8, 1, 746, 1, 13);
    pushExp(8, 1, 746, 0, 13);
    applyStimulus(746, 4);

    $display("[TB] unknown tone");
    pushExp(0, 0, 600, 0, 15);
    applyStimulus(600, 3);

    $display("[TB] A5 tolerance edge");
    pushExp(0, 0, 900, 0, 18);
    pushExp(6, 1, 900, 1, 20);
    pushExp(6, 1, 900, 0, 20);
    applyStimulus(900, 5);
    pushExp(0, 0, 901, 0, 23);
    applyStimulus(901, 2);

    $display("[TB] G5 lock then timeout");
    pushExp(0, 0, 996, 0, 25);
    pushExp(5, 1, 996, 1, 27);
    pushExp(5, 1, 996, 0, 27);
    applyStimulus(996, 5);
    pushExp(0, 0, 0, 0, 28);
    holdLow(4500);

    $display("[TB] B5 relock after timeout");
    pushExp(0, 0, 790, 0, 30);
    pushExp(7, 1, 790, 1, 32);
    pushExp(7, 1, 790, 0, 32);
    applyStimulus(790, 4);

    $display("[TB] reset while locked");
    tone = 1'b1;
    riseCount++;
    repeat (395) @(negedge clock);
    tone = 1'b0;
    repeat (100) @(negedge clock);
    pushExp(0, 0, 0, 0, 33);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_note",   32'(note),   32'd0);
    checkOutput("async_reset_valid",  32'(valid),  32'd0);
    checkOutput("async_reset_period", 32'(period), 32'd0);
    checkOutput("async_reset_change", 32'(change), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    holdLow(300);

    $display("[TB] F5 relock after reset");
    pushExp(0, 0, 1118, 0, 35);
    pushExp(4, 1, 1118, 1, 37);
    pushExp(4, 1, 1118, 0, 37);
    applyStimulus(1118, 5);
    holdLow(200);

    checkOutput("pending_updates", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
